// File: rtl/femb_dts_pll_reset_seq.sv
// rtl/femb_dts_pll_reset_seq.sv - FEMB DTS PLL reset/lock supervisor.
// Optional lock-loss counter and timeout flag built only with FEMB_DTS_LOCK_LOSS_CNT_EN.
module femb_dts_pll_reset_seq #(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES         = 2
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        pll_locked,
  input  logic        relock_req,
  input  logic        cnt_clear,
  output logic        pll_rst,
  output logic        domain_rst,
  output logic        ready,
  output logic        timeout_seen,
  output logic [15:0] lock_loss_cnt
);

  localparam int MAX_HS = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_P  = (MAX_HS > LOCK_TIMEOUT_CYCLES) ? MAX_HS : LOCK_TIMEOUT_CYCLES;
  localparam int TW     = $clog2(MAX_P) + 1;

  localparam logic [TW-1:0] HOLD_LAST    = TW'(RST_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE    = TW'(1);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  logic                   pll_rst_q, domain_rst_q, ready_q;
  logic                   loss_evt, timeout_evt;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + TIMER_ONE;
    loss_evt    = 1'b0;
    timeout_evt = 1'b0;
    case (state_q)
      RESET_PLL: begin
        if (timer_q == HOLD_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d     = RESET_PLL;
          timeout_evt = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) state_d = WAIT_LOCK;
        else if (timer_q == STABLE_LAST) state_d = RUN;
      end
      RUN: begin
        // Timer is idle in RUN so it can never wrap while locked for a long time.
        timer_d = timer_q;
        if (!locked_s) begin
          state_d  = RESET_PLL;
          loss_evt = 1'b1;
        end
      end
      default: state_d = RESET_PLL;
    endcase
    // A forced relock overrides everything and is never counted as a loss or timeout.
    if (relock_req) begin
      state_d     = RESET_PLL;
      loss_evt    = 1'b0;
      timeout_evt = 1'b0;
    end
    if ((state_d != state_q) || relock_req) timer_d = '0;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= RESET_PLL;
      timer_q      <= '0;
      sync_q       <= '0;
      pll_rst_q    <= 1'b1;
      domain_rst_q <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      sync_q       <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      pll_rst_q    <= (state_d == RESET_PLL);
      domain_rst_q <= (state_d != RUN);
      ready_q      <= (state_d == RUN);
    end
  end

  assign pll_rst    = pll_rst_q;
  assign domain_rst = domain_rst_q;
  assign ready      = ready_q;

`ifdef FEMB_DTS_LOCK_LOSS_CNT_EN
  logic [15:0] lock_loss_cnt_q;
  logic        timeout_seen_q;

  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_loss_cnt_q <= 16'd0;
      timeout_seen_q  <= 1'b0;
    end else begin
      if (cnt_clear) begin
        lock_loss_cnt_q <= loss_evt ? 16'd1 : 16'd0;
      end else if (loss_evt && (lock_loss_cnt_q != 16'hFFFF)) begin
        lock_loss_cnt_q <= lock_loss_cnt_q + 16'd1;
      end
      if (timeout_evt) timeout_seen_q <= 1'b1;
      else if (cnt_clear) timeout_seen_q <= 1'b0;
    end
  end

  assign lock_loss_cnt = lock_loss_cnt_q;
  assign timeout_seen  = timeout_seen_q;
`else
  logic unused_cnt_inputs;
  assign unused_cnt_inputs = ^{cnt_clear, loss_evt, timeout_evt};
  assign lock_loss_cnt     = 16'd0;
  assign timeout_seen      = 1'b0;
`endif

endmodule

// File: tb/tb_femb_dts_pll_reset_seq.sv
// tb/tb_femb_dts_pll_reset_seq.sv - directed bench for femb_dts_pll_reset_seq.
// Expected counter values follow FEMB_DTS_LOCK_LOSS_CNT_EN.
module tb_femb_dts_pll_reset_seq;

  logic        refclk = 1'b0;
  logic        rst, pll_locked, relock_req, cnt_clear;
  logic        pll_rst, domain_rst, ready, timeout_seen;
  logic [15:0] lock_loss_cnt;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_cnt = 16'd0;

`ifdef FEMB_DTS_LOCK_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  always #5 refclk = ~refclk;

  femb_dts_pll_reset_seq #(
    .RST_HOLD_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(32), .SYNC_STAGES(2)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .relock_req(relock_req),
    .cnt_clear(cnt_clear), .pll_rst(pll_rst), .domain_rst(domain_rst), .ready(ready),
    .timeout_seen(timeout_seen), .lock_loss_cnt(lock_loss_cnt)
  );

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic bump_loss();
    if (CNT_EN) exp_cnt = (exp_cnt == 16'hFFFF) ? 16'hFFFF : exp_cnt + 16'd1;
  endtask

  task automatic test_reset();
    int hold, n;
    rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0; cnt_clear = 1'b0;
    repeat (3) tick();
    tests++; if (pll_rst !== 1'b1) begin fails++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
    tests++; if (domain_rst !== 1'b1) begin fails++; $display("FAIL reset_domain_rst: got %b want 1", domain_rst); end
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", ready); end
    tests++; if (timeout_seen !== 1'b0) begin fails++; $display("FAIL reset_timeout_seen: got %b want 0", timeout_seen); end
    tests++; if (lock_loss_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0h want 0", lock_loss_cnt); end
    rst = 1'b0;
    hold = 1;
    for (int i = 0; i < 20 && pll_rst; i++) begin
      tick();
      if (pll_rst) hold++;
    end
    tests++; if (hold != 4) begin fails++; $display("FAIL reset_hold_width: got %0d want 4", hold); end
    repeat (6) tick();
    pll_locked = 1'b1;
    wait_ready(n);
    tests++; if (n != 11) begin fails++; $display("FAIL reset_release_latency: got %0d want 11", n); end
    tests++; if (domain_rst !== 1'b0) begin fails++; $display("FAIL reset_domain_rel: got %b want 0", domain_rst); end
    tests++; if (lock_loss_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt_after: got %0h want 0", lock_loss_cnt); end
  endtask

  task automatic test_glitch();
    int n;
    rst = 1'b1; pll_locked = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (8) tick();
    pll_locked = 1'b1;
    repeat (4) tick();
    tests++; if (domain_rst !== 1'b1) begin fails++; $display("FAIL glitch_stable_domain: got %b want 1", domain_rst); end
    pll_locked = 1'b0;
    repeat (3) tick();
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL glitch_no_ready: got %b want 0", ready); end
    pll_locked = 1'b1;
    wait_ready(n);
    tests++; if (n != 11) begin fails++; $display("FAIL glitch_release_latency: got %0d want 11", n); end
    tests++; if (lock_loss_cnt !== 16'd0) begin fails++; $display("FAIL glitch_cnt: got %0h want 0", lock_loss_cnt); end
  endtask

  task automatic test_loss();
    int n;
    pll_locked = 1'b0;
    repeat (2) tick();
    tests++; if (domain_rst !== 1'b0) begin fails++; $display("FAIL loss_early: got %b want 0", domain_rst); end
    tick();
    bump_loss();
    tests++; if (domain_rst !== 1'b1) begin fails++; $display("FAIL loss_domain_rst: got %b want 1", domain_rst); end
    tests++; if (pll_rst !== 1'b1) begin fails++; $display("FAIL loss_pll_rst: got %b want 1", pll_rst); end
    tests++; if (lock_loss_cnt !== exp_cnt) begin fails++; $display("FAIL loss_cnt: got %0h want %0h", lock_loss_cnt, exp_cnt); end
    pll_locked = 1'b1;
    wait_ready(n);
    tests++; if (n != 13) begin fails++; $display("FAIL loss_relock_latency: got %0d want 13", n); end
  endtask

  task automatic test_relock();
    int n;
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    tests++; if (pll_rst !== 1'b1) begin fails++; $display("FAIL relock_pll_rst: got %b want 1", pll_rst); end
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL relock_ready: got %b want 0", ready); end
    tests++; if (lock_loss_cnt !== exp_cnt) begin fails++; $display("FAIL relock_cnt: got %0h want %0h", lock_loss_cnt, exp_cnt); end
    wait_ready(n);
    tests++; if (n != 13) begin fails++; $display("FAIL relock_latency: got %0d want 13", n); end
  endtask

  task automatic test_timeout();
    int   rises[3];
    int   nr, n;
    logic prev;
    rises = '{0, 0, 0};
    nr = 0;
    prev = pll_rst;
    pll_locked = 1'b0;
    for (int i = 1; i <= 120 && nr < 3; i++) begin
      tick();
      if (pll_rst && !prev) begin
        rises[nr] = i;
        nr++;
        if (nr == 1) begin
          bump_loss();
          tests++; if (timeout_seen !== 1'b0) begin fails++; $display("FAIL timeout_flag_early: got %b want 0", timeout_seen); end
        end
      end
      prev = pll_rst;
    end
    tests++; if (nr != 3) begin fails++; $display("FAIL timeout_pulses: got %0d want 3", nr); end
    tests++; if (rises[2] - rises[1] != 36) begin fails++; $display("FAIL timeout_period: got %0d want 36", rises[2] - rises[1]); end
    tests++; if (rises[1] - rises[0] != 36) begin fails++; $display("FAIL timeout_first_gap: got %0d want 36", rises[1] - rises[0]); end
    tests++; if (timeout_seen !== CNT_EN) begin fails++; $display("FAIL timeout_seen: got %b want %b", timeout_seen, CNT_EN); end
    tests++; if (lock_loss_cnt !== exp_cnt) begin fails++; $display("FAIL timeout_cnt: got %0h want %0h", lock_loss_cnt, exp_cnt); end
    pll_locked = 1'b1;
    wait_ready(n);
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL timeout_recover: got %b want 1", ready); end
  endtask

  task automatic test_sat_clear();
    int n;
`ifdef FEMB_DTS_LOCK_LOSS_CNT_EN
    force dut.lock_loss_cnt_q = 16'hFFFE;
    #1;
    release dut.lock_loss_cnt_q;
    exp_cnt = 16'hFFFE;
    repeat (2) begin
      pll_locked = 1'b0;
      repeat (3) tick();
      bump_loss();
      pll_locked = 1'b1;
      wait_ready(n);
    end
    tests++; if (lock_loss_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_hold: got %0h want ffff", lock_loss_cnt); end
`endif
    pll_locked = 1'b0;
    repeat (2) tick();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    exp_cnt = CNT_EN ? 16'd1 : 16'd0;
    tests++; if (pll_rst !== 1'b1) begin fails++; $display("FAIL clear_loss_pll_rst: got %b want 1", pll_rst); end
    tests++; if (lock_loss_cnt !== exp_cnt) begin fails++; $display("FAIL clear_with_loss: got %0h want %0h", lock_loss_cnt, exp_cnt); end
    tests++; if (timeout_seen !== 1'b0) begin fails++; $display("FAIL clear_timeout_seen: got %b want 0", timeout_seen); end
    pll_locked = 1'b1;
    wait_ready(n);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    exp_cnt = 16'd0;
    tests++; if (lock_loss_cnt !== 16'd0) begin fails++; $display("FAIL clear_plain: got %0h want 0", lock_loss_cnt); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL clear_keeps_run: got %b want 1", ready); end
  endtask

  task automatic test_rst_mid();
    pll_locked = 1'b0;
    repeat (3) tick();
    bump_loss();
    tests++; if (lock_loss_cnt !== exp_cnt) begin fails++; $display("FAIL mid_pre_cnt: got %0h want %0h", lock_loss_cnt, exp_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (pll_rst !== 1'b1) begin fails++; $display("FAIL mid_pll_rst: got %b want 1", pll_rst); end
    tests++; if (domain_rst !== 1'b1) begin fails++; $display("FAIL mid_domain_rst: got %b want 1", domain_rst); end
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL mid_ready: got %b want 0", ready); end
    tests++; if (lock_loss_cnt !== 16'd0) begin fails++; $display("FAIL mid_cnt: got %0h want 0", lock_loss_cnt); end
    tests++; if (timeout_seen !== 1'b0) begin fails++; $display("FAIL mid_timeout_seen: got %b want 0", timeout_seen); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_loss();
    test_relock();
    test_timeout();
    test_sat_clear();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
